// File: rtl/shiftreg_ctrl_pkg.sv
// rtl/shiftreg_ctrl_pkg.sv - shared encodings for the shift register load sequencer
//
// Purpose : FSM state encoding and requester ids used by shiftreg_ctrl and rr_arb2.
// Ports   : none (package).
package shiftreg_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/shiftreg_ctrl_rr_arb2.sv
// rtl/shiftreg_ctrl_rr_arb2.sv - 2-input round-robin arbiter
//
// Purpose : Grants one of two requesters; on contention the requester not granted last wins.
// Ports   : clk, rst_n (async, active-low), req[1:0], en (arbitration allowed this cycle),
//           grant[1:0] (one-hot or zero, combinational).
module rr_arb2
   import shiftreg_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] grant
);

   // Requester preferred when both ask; after reset requester 0 goes first.
   logic prio;

   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (req == 2'b11) begin
            grant = (prio == ID_REQ1) ? 2'b10 : 2'b01;
         end else begin
            grant = req;
         end
      end
   end

   // Pointer moves only when something is actually granted: whoever won
   // loses the next tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= ID_REQ0;
      end else if (|grant) begin
         prio <= grant[0] ? ID_REQ1 : ID_REQ0;
      end
   end

endmodule

// File: rtl/shiftreg_ctrl.sv
// rtl/shiftreg_ctrl.sv - load sequencer and 2-way arbiter for an N-bit serial-in shift register
//
// Purpose : Accepts parallel words from two requesters (valid/ready), shifts the granted word
//           MSB-first into the external shift register, then reports the settled Q.
// Ports   : CLK, RSTn (async, active-low)
//           req0_valid/req0_data/req0_ready, req1_valid/req1_data/req1_ready : load requests
//           sr_en, sr_in, sr_q : shift register EN, serial in, Q
//           busy : load in progress; done/done_id/result : one-cycle completion report
//           load_err : only with SHIFTREG_CTRL_VERIFY_EN defined; Q differs from the loaded word
module shiftreg_ctrl
   import shiftreg_ctrl_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = 2
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         req0_valid,
   input  logic [N-1:0] req0_data,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [N-1:0] req1_data,
   output logic         req1_ready,
   output logic         sr_en,
   output logic         sr_in,
   input  logic [N-1:0] sr_q,
   output logic         busy,
   output logic         done,
   output logic         done_id,
   output logic [N-1:0] result
`ifdef SHIFTREG_CTRL_VERIFY_EN
   ,
   output logic         load_err
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [N-1:0]     word;
   logic             id;
   logic [1:0]       grant;
   logic [N-1:0]     grant_data;

   rr_arb2 u_arb (
      .clk   (CLK),
      .rst_n (RSTn),
      .req   ({req1_valid, req0_valid}),
      .en    (state == ST_IDLE),
      .grant (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign grant_data = grant[1] ? req1_data : req0_data;

   // Q only settles on the edge that ends SHIFT, so it is sampled during the
   // DONE cycle (while done is high) rather than registered on that same edge.
   assign result = done ? sr_q : '0;

`ifdef SHIFTREG_CTRL_VERIFY_EN
   assign load_err = done && (sr_q != word);
`endif

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         word    <= '0;
         id      <= ID_REQ0;
         sr_en   <= 1'b0;
         sr_in   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  word  <= grant_data;
                  id    <= grant[1] ? ID_REQ1 : ID_REQ0;
                  cnt   <= CNT_LAST;
                  // Present the MSB right away so the first SHIFT cycle already shifts.
                  sr_en <= 1'b1;
                  sr_in <= grant_data[N-1];
                  busy  <= 1'b1;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (cnt == '0) begin
                  sr_en   <= 1'b0;
                  sr_in   <= 1'b0;
                  done    <= 1'b1;
                  done_id <= id;
                  state   <= ST_DONE;
               end else begin
                  cnt   <= cnt - 1'b1;
                  sr_in <= word[cnt - 1'b1];
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               done_id <= 1'b0;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// tb/tb_shiftreg_ctrl.sv - self-checking bench for shiftreg_ctrl with an attached shift register
module tb_shiftreg_ctrl;

   localparam int N = 4;

   logic         CLK;
   logic         RSTn;
   logic         v0, v1;
   logic [N-1:0] d0, d1;
   logic         req0_ready, req1_ready;
   logic         sr_en, sr_in;
   logic [N-1:0] sr_q;
   logic         busy, done, done_id;
   logic [N-1:0] result;
   logic         load_err;

   logic [N-1:0] sr_raw;
   logic         fault;

   shiftreg_ctrl #(.N(N), .CNT_W(2)) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .req0_valid (v0),
      .req0_data  (d0),
      .req0_ready (req0_ready),
      .req1_valid (v1),
      .req1_data  (d1),
      .req1_ready (req1_ready),
      .sr_en      (sr_en),
      .sr_in      (sr_in),
      .sr_q       (sr_q),
      .busy       (busy),
      .done       (done),
      .done_id    (done_id),
      .result     (result)
`ifdef SHIFTREG_CTRL_VERIFY_EN
      ,
      .load_err   (load_err)
`endif
   );

`ifndef SHIFTREG_CTRL_VERIFY_EN
   assign load_err = 1'b0;
`endif

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Plant: serial-in shift register, optionally with Q[0] stuck at 0.
   initial sr_raw = '0;
   always @(posedge CLK) if (sr_en) sr_raw <= {sr_raw[N-2:0], sr_in};
   assign sr_q = fault ? {sr_raw[N-1:1], 1'b0} : sr_raw;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Transaction-level reference: which requester must win, and what each
   // cycle of a load must look like relative to its accept cycle.
   int           phase = 0;      // 0 idle, 1..N shifting, N+1 done
   int           last  = 1;      // last winner; 1 so requester 0 wins first
   logic [N-1:0] exp_word;
   logic         exp_id;
   int           n_done = 0;
   logic         last_err;
   int           grants[$];
   int           acc_cyc[$];
   logic [N:0]   done_q[$];

   always @(negedge CLK) begin
      int           win;
      logic [N-1:0] exp_res;
      if (!RSTn) begin
         phase = 0;
         last  = 1;
      end else begin
         check("busy", busy, phase != 0);
         if (phase >= 1 && phase <= N) begin
            check("sr_en_shift", sr_en, 1);
            check("sr_in_bit", sr_in, exp_word[N-phase]);
            check("done_early", done, 0);
         end else if (phase == N + 1) begin
            exp_res = fault ? (exp_word & ~N'(1)) : exp_word;
            check("sr_en_done", sr_en, 0);
            check("done_pulse", done, 1);
            check("result", result, exp_res);
            check("done_id", done_id, exp_id);
            check("load_err", load_err, exp_res != exp_word);
            last_err = load_err;
            done_q.push_back({done_id, result});
            n_done++;
         end else begin
            check("sr_en_idle", sr_en, 0);
            check("sr_in_idle", sr_in, 0);
            check("done_idle", done, 0);
         end

         if (phase == 0) begin
            if (v0 && v1)  win = 1 - last;
            else if (v0)   win = 0;
            else if (v1)   win = 1;
            else           win = -1;
            check("req0_ready", req0_ready, win == 0);
            check("req1_ready", req1_ready, win == 1);
         end else begin
            win = -1;
            check("req0_ready_holdoff", req0_ready, 0);
            check("req1_ready_holdoff", req1_ready, 0);
         end

         if (phase == N + 1)          phase = 0;
         else if (phase != 0)         phase++;
         if (win >= 0) begin
            exp_word = (win == 1) ? d1 : d0;
            exp_id   = (win == 1);
            last     = win;
            grants.push_back(win);
            acc_cyc.push_back(cyc);
            phase    = 1;
         end
      end
   end

   logic rnd  = 1'b0;
   logic hold = 1'b0;

   // One clock of requester behaviour: drop (or refresh in hold mode) a word once accepted.
   task automatic step();
      logic a0, a1;
      @(negedge CLK);
      a0 = req0_ready;
      a1 = req1_ready;
      @(posedge CLK);
      #1;
      if (a0) begin
         if (hold) d0 = N'($urandom); else v0 = 1'b0;
      end else if (rnd && !v0 && $urandom_range(0, 2) == 0) begin
         v0 = 1'b1; d0 = N'($urandom);
      end
      if (a1) begin
         if (hold) d1 = N'($urandom); else v1 = 1'b0;
      end else if (rnd && !v1 && $urandom_range(0, 2) == 0) begin
         v1 = 1'b1; d1 = N'($urandom);
      end
   endtask

   task automatic wait_done(input int target, input int budget);
      int k = 0;
      while (n_done < target && k < budget) begin step(); k++; end
      if (n_done < target) check("timeout_done", n_done, target);
   endtask

   task automatic wait_acc(input int target, input int budget);
      int k = 0;
      while (acc_cyc.size() < target && k < budget) begin step(); k++; end
      if (acc_cyc.size() < target) check("timeout_accept", acc_cyc.size(), target);
   endtask

   task automatic drain();
      int k = 0;
      v0 = 1'b0; v1 = 1'b0;
      step();
      while (busy && k < 20) begin step(); k++; end
      if (busy) check("timeout_drain", busy, 0);
   endtask

   initial begin
      int nd;
      RSTn = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; fault = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_sr_en", sr_en, 0);
      check("rst_sr_in", sr_in, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_done_id", done_id, 0);
      check("rst_result", result, 0);
      check("rst_ready", {req1_ready, req0_ready}, 0);
      check("rst_load_err", load_err, 0);

      // Contention straight out of reset: requester 0 first, then requester 1.
      v0 = 1'b1; d0 = 4'h3; v1 = 1'b1; d1 = 4'hC;
      RSTn = 1'b1;
      wait_done(2, 40);
      check("cont_ngrants", grants.size(), 2);
      if (grants.size() >= 2 && done_q.size() >= 2) begin
         check("cont_first", grants[0], 0);
         check("cont_second", grants[1], 1);
         check("cont_res0", done_q[0], {1'b0, 4'h3});
         check("cont_res1", done_q[1], {1'b1, 4'hC});
      end
      drain();

      // Single load of 1011 from requester 0.
      done_q.delete();
      v0 = 1'b1; d0 = 4'b1011;
      wait_done(n_done + 1, 20);
      if (done_q.size() >= 1) check("single_res", done_q[0], {1'b0, 4'b1011});
      drain();

      // Fairness: both held valid across several loads.
      grants.delete();
      hold = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = N'($urandom); d1 = N'($urandom);
      wait_done(n_done + 4, 60);
      hold = 1'b0;
      drain();
      check("fair_min_grants", grants.size() >= 4, 1);
      for (int i = 1; i < grants.size(); i++) check("fair_alternate", grants[i] != grants[i-1], 1);

      // Hold-off: requester 1 raises valid mid-SHIFT and is taken in the first IDLE cycle.
      acc_cyc.delete();
      v0 = 1'b1; d0 = N'($urandom);
      wait_acc(1, 10);
      step(); step();
      v1 = 1'b1; d1 = N'($urandom);
      wait_acc(2, 20);
      if (acc_cyc.size() >= 2) check("holdoff_spacing", acc_cyc[1] - acc_cyc[0], N + 2);
      drain();

      // Reset in the middle of a load: outputs drop at once, no done follows.
      acc_cyc.delete();
      v0 = 1'b1; d0 = 4'hA;
      wait_acc(1, 10);
      step();
      #2;
      RSTn = 1'b0;
      #1;
      check("midrst_sr_en", sr_en, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      nd = n_done;
      @(posedge CLK);
      #3;
      RSTn = 1'b1;
      repeat (8) step();
      check("midrst_no_done", n_done, nd);
      check("midrst_idle", busy, 0);

`ifdef SHIFTREG_CTRL_VERIFY_EN
      // Stuck-at-0 on Q[0] must be flagged; a clean load must not be.
      fault = 1'b1;
      v0 = 1'b1; d0 = 4'h1;
      wait_done(n_done + 1, 20);
      check("verify_err_flagged", last_err, 1);
      drain();
      fault = 1'b0;
      v0 = 1'b1; d0 = 4'h1;
      wait_done(n_done + 1, 20);
      check("verify_err_clean", last_err, 0);
      drain();
`endif

      // Random traffic against the reference.
      nd = n_done;
      rnd = 1'b1;
      repeat (400) step();
      rnd = 1'b0;
      drain();
      check("random_made_progress", n_done > nd + 20, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, %0d checks so far", n_tests);
      $fatal(1);
   end

endmodule
